frog_hop_ctrl: RTL and testbench

//  Sequences the frog position datapath: converts raw key levels into discrete fixed-length hops.

---
 rtl/frog_pkg.sv | 36 +++
 rtl/frog_hop_ctrl_if.sv | 39 +++
 rtl/frog_key_edge.sv | 29 ++
 rtl/frog_hop_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_frog_hop_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/frog_pkg.sv
// Shared types and default parameters for the frog hop controller slice.
package frog_pkg;

    localparam int unsigned DEF_HOP_STEPS      = 10;
    localparam int unsigned DEF_COOLDOWN_TICKS = 4;
    localparam int unsigned DEF_RESPAWN_TICKS  = 60;
    localparam int unsigned DEF_START_LIVES    = 3;

    localparam int unsigned LIVES_W  = 2;
    localparam int unsigned HOME_W   = 3;
    localparam int unsigned HOME_MAX = 7;

    typedef enum logic [2:0] {
        IDLE,
        HOP,
        COOLDOWN,
        DYING,
        GAME_OVER
    } hop_state_t;

    typedef enum logic [2:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
    } keys_t;

endpackage

// File: rtl/frog_hop_ctrl_if.sv
// Signal bundle between the frog hop controller and its neighbours (keypad, timer, collision, mover).
interface frog_hop_ctrl_if;
    import frog_pkg::*;

    logic               frame_tick;
    logic               key_up;
    logic               key_down;
    logic               key_left;
    logic               key_right;
    logic               collision;
    logic               reached_home;
    logic               restart;

    logic               up;
    logic               down;
    logic               left;
    logic               right;
    logic               move_tick;
    logic               reset_position;
    logic [LIVES_W-1:0] lives;
    logic [HOME_W-1:0]  home_count;
    logic               hop_active;
    logic               game_over;

    modport master (
        output frame_tick, key_up, key_down, key_left, key_right,
               collision, reached_home, restart,
        input  up, down, left, right, move_tick, reset_position,
               lives, home_count, hop_active, game_over
    );

    modport slave (
        input  frame_tick, key_up, key_down, key_left, key_right,
               collision, reached_home, restart,
        output up, down, left, right, move_tick, reset_position,
               lives, home_count, hop_active, game_over
    );

endinterface

// File: rtl/frog_key_edge.sv
// Rising-edge detect on the four raw key levels, priority-encoded up > down > left > right.
module frog_key_edge
    import frog_pkg::*;
(
    input  logic  CLK,
    input  logic  RESETn,
    input  keys_t keys,
    output dir_t  edge_dir_c
);

    keys_t prev_q;
    keys_t rise;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) prev_q <= '0;
        else         prev_q <= keys;
    end

    assign rise = keys & ~prev_q;

    always_comb begin
        edge_dir_c = DIR_NONE;
        if      (rise.up)    edge_dir_c = DIR_UP;
        else if (rise.down)  edge_dir_c = DIR_DOWN;
        else if (rise.left)  edge_dir_c = DIR_LEFT;
        else if (rise.right) edge_dir_c = DIR_RIGHT;
    end

endmodule

// File: rtl/frog_hop_ctrl.sv
// Frog hop sequencer: key edges to fixed-length hops, cooldown, death/respawn and home flow.
// Optional FROG_HOP_QUEUE_EN keeps a one-deep queue for a key edge seen during HOP/COOLDOWN.
module frog_hop_ctrl
    import frog_pkg::*;
#(
    parameter int unsigned HOP_STEPS      = DEF_HOP_STEPS,
    parameter int unsigned COOLDOWN_TICKS = DEF_COOLDOWN_TICKS,
    parameter int unsigned RESPAWN_TICKS  = DEF_RESPAWN_TICKS,
    parameter int unsigned START_LIVES    = DEF_START_LIVES
)(
    input  logic            CLK,
    input  logic            RESETn,
    frog_hop_ctrl_if.slave  bus
);

    localparam int unsigned STEP_W   = $clog2(HOP_STEPS + 1);
    localparam int unsigned TICK_MAX = (RESPAWN_TICKS > COOLDOWN_TICKS) ? RESPAWN_TICKS : COOLDOWN_TICKS;
    localparam int unsigned TICK_W   = $clog2(TICK_MAX + 1);

    hop_state_t         state_q, state_d;
    dir_t               dir_q, dir_d;
    dir_t               pend_q, pend_d;
    dir_t               edge_dir_c;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [HOME_W-1:0]  home_q, home_d;
    logic               rst_pos_q, rst_pos_d;
    logic               hop_active_q, game_over_q;
    logic               live_c;
    keys_t              keys;
`ifdef FROG_HOP_QUEUE_EN
    dir_t               queue_q, queue_d;
`endif

    assign keys = {bus.key_up, bus.key_down, bus.key_left, bus.key_right};

    frog_key_edge u_key_edge (
        .CLK        (CLK),
        .RESETn     (RESETn),
        .keys       (keys),
        .edge_dir_c (edge_dir_c)
    );

    assign live_c = (state_q == IDLE) || (state_q == HOP) || (state_q == COOLDOWN);

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q      <= IDLE;
            dir_q        <= DIR_NONE;
            pend_q       <= DIR_NONE;
            step_q       <= '0;
            tick_q       <= '0;
            lives_q      <= LIVES_W'(START_LIVES);
            home_q       <= '0;
            rst_pos_q    <= 1'b0;
            hop_active_q <= 1'b0;
            game_over_q  <= 1'b0;
`ifdef FROG_HOP_QUEUE_EN
            queue_q      <= DIR_NONE;
`endif
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            pend_q       <= pend_d;
            step_q       <= step_d;
            tick_q       <= tick_d;
            lives_q      <= lives_d;
            home_q       <= home_d;
            rst_pos_q    <= rst_pos_d;
            hop_active_q <= (state_d == HOP);
            game_over_q  <= (state_d == GAME_OVER);
`ifdef FROG_HOP_QUEUE_EN
            queue_q      <= queue_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        pend_d    = pend_q;
        step_d    = step_q;
        tick_d    = tick_q;
        lives_d   = lives_q;
        home_d    = home_q;
        rst_pos_d = 1'b0;
`ifdef FROG_HOP_QUEUE_EN
        queue_d   = queue_q;
        if ((state_q == HOP || state_q == COOLDOWN) && queue_q == DIR_NONE && edge_dir_c != DIR_NONE)
            queue_d = edge_dir_c;
`endif

        case (state_q)
            IDLE: begin
                if (edge_dir_c != DIR_NONE) pend_d = edge_dir_c;
                // An edge arriving on the launch tick is dropped with the pending slot
                if (bus.frame_tick && pend_q != DIR_NONE) begin
                    state_d = HOP;
                    dir_d   = pend_q;
                    step_d  = STEP_W'(HOP_STEPS);
                    pend_d  = DIR_NONE;
                end
            end
            HOP: begin
                if (bus.frame_tick) begin
                    if (step_q <= STEP_W'(1)) begin
                        state_d = COOLDOWN;
                        dir_d   = DIR_NONE;
                        step_d  = '0;
                        tick_d  = TICK_W'(COOLDOWN_TICKS);
                    end else begin
                        step_d  = step_q - STEP_W'(1);
                    end
                end
            end
            COOLDOWN: begin
                if (bus.frame_tick) begin
                    if (tick_q <= TICK_W'(1)) begin
                        state_d = IDLE;
                        tick_d  = '0;
`ifdef FROG_HOP_QUEUE_EN
                        pend_d  = queue_d;
                        queue_d = DIR_NONE;
`endif
                    end else begin
                        tick_d  = tick_q - TICK_W'(1);
                    end
                end
            end
            DYING: begin
                if (bus.frame_tick) begin
                    if (tick_q <= TICK_W'(1)) begin
                        tick_d = '0;
                        if (lives_q == '0) begin
                            state_d = GAME_OVER;
                        end else begin
                            state_d   = IDLE;
                            rst_pos_d = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q - TICK_W'(1);
                    end
                end
            end
            GAME_OVER: begin
                if (bus.restart) begin
                    state_d   = IDLE;
                    lives_d   = LIVES_W'(START_LIVES);
                    home_d    = '0;
                    rst_pos_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Collision outranks reached_home; both abort any hop and clear stored edges
        if (live_c && bus.collision) begin
            state_d = DYING;
            dir_d   = DIR_NONE;
            pend_d  = DIR_NONE;
            tick_d  = TICK_W'(RESPAWN_TICKS);
            lives_d = (lives_q != '0) ? lives_q - LIVES_W'(1) : '0;
`ifdef FROG_HOP_QUEUE_EN
            queue_d = DIR_NONE;
`endif
        end else if (live_c && bus.reached_home) begin
            state_d   = IDLE;
            dir_d     = DIR_NONE;
            pend_d    = DIR_NONE;
            step_d    = '0;
            rst_pos_d = 1'b1;
            home_d    = (home_q != HOME_W'(HOME_MAX)) ? home_q + HOME_W'(1) : home_q;
`ifdef FROG_HOP_QUEUE_EN
            queue_d   = DIR_NONE;
`endif
        end
    end

    assign bus.up             = (dir_q == DIR_UP);
    assign bus.down           = (dir_q == DIR_DOWN);
    assign bus.left           = (dir_q == DIR_LEFT);
    assign bus.right          = (dir_q == DIR_RIGHT);
    assign bus.move_tick      = bus.frame_tick & live_c;
    assign bus.reset_position = rst_pos_q;
    assign bus.lives          = lives_q;
    assign bus.home_count     = home_q;
    assign bus.hop_active     = hop_active_q;
    assign bus.game_over      = game_over_q;

endmodule

// File: tb/tb_frog_hop_ctrl.sv
// Randomized bench for frog_hop_ctrl against a rule-level game model; honours FROG_HOP_QUEUE_EN.
module tb_frog_hop_ctrl;

    localparam int N_CYCLES   = 20000;
    localparam int R_STEPS    = 10;
    localparam int R_COOLDOWN = 4;
    localparam int R_RESPAWN  = 60;
    localparam int R_LIVES    = 3;
`ifdef FROG_HOP_QUEUE_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif

    // Game phases of the reference model
    localparam int P_IDLE = 0, P_HOP = 1, P_COOL = 2, P_DYING = 3, P_OVER = 4;

    logic CLK;
    logic RESETn;
    frog_hop_ctrl_if bus ();

    frog_hop_ctrl dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .bus    (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        n_vec++;
        if (obs !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: direction codes 0 none, 1 up, 2 down, 3 left, 4 right
    int       m_phase, m_dir, m_pend, m_queue, m_steps_left, m_ticks_left, m_lives, m_homes;
    bit       m_rp;
    bit [3:0] m_prev;

    task automatic model_reset();
        m_phase = P_IDLE; m_dir = 0; m_pend = 0; m_queue = 0;
        m_steps_left = 0; m_ticks_left = 0;
        m_lives = R_LIVES; m_homes = 0; m_rp = 1'b0; m_prev = 4'b0;
    endtask

    function automatic int first_press(input bit [3:0] k, input bit [3:0] prev);
        bit [3:0] pressed;
        pressed = k & ~prev;
        for (int i = 3; i >= 0; i--)
            if (pressed[i]) return 4 - i;
        return 0;
    endfunction

    task automatic model_clock(input bit ft, input bit [3:0] k, input bit col, input bit hm, input bit rs);
        int  press;
        bit  alive;
        press  = first_press(k, m_prev);
        m_prev = k;
        alive  = (m_phase == P_IDLE) || (m_phase == P_HOP) || (m_phase == P_COOL);
        m_rp   = 1'b0;
        if (alive && col) begin
            m_phase = P_DYING; m_dir = 0; m_pend = 0; m_queue = 0;
            if (m_lives > 0) m_lives--;
            m_ticks_left = R_RESPAWN;
        end else if (alive && hm) begin
            if (m_homes < 7) m_homes++;
            m_rp = 1'b1; m_phase = P_IDLE; m_dir = 0; m_pend = 0; m_queue = 0;
        end else begin
            if ((m_phase == P_HOP || m_phase == P_COOL) && QEN && press != 0 && m_queue == 0)
                m_queue = press;
            case (m_phase)
                P_IDLE: begin
                    if (ft && m_pend != 0) begin
                        m_dir = m_pend; m_pend = 0; m_steps_left = R_STEPS; m_phase = P_HOP;
                    end else if (press != 0) begin
                        m_pend = press;
                    end
                end
                P_HOP: if (ft) begin
                    m_steps_left--;
                    if (m_steps_left == 0) begin
                        m_phase = P_COOL; m_dir = 0; m_ticks_left = R_COOLDOWN;
                    end
                end
                P_COOL: if (ft) begin
                    m_ticks_left--;
                    if (m_ticks_left == 0) begin
                        m_phase = P_IDLE; m_pend = m_queue; m_queue = 0;
                    end
                end
                P_DYING: if (ft) begin
                    m_ticks_left--;
                    if (m_ticks_left == 0) begin
                        if (m_lives == 0) m_phase = P_OVER;
                        else begin m_rp = 1'b1; m_phase = P_IDLE; end
                    end
                end
                default: if (rs) begin
                    m_lives = R_LIVES; m_homes = 0; m_rp = 1'b1; m_phase = P_IDLE;
                end
            endcase
        end
    endtask

    task automatic check_outputs(input bit ft);
        check("up",             bus.up,             m_dir == 1);
        check("down",           bus.down,           m_dir == 2);
        check("left",           bus.left,           m_dir == 3);
        check("right",          bus.right,          m_dir == 4);
        check("move_tick",      bus.move_tick,      ft && m_phase <= P_COOL);
        check("reset_position", bus.reset_position, m_rp);
        check("lives",          bus.lives,          m_lives);
        check("home_count",     bus.home_count,     m_homes);
        check("hop_active",     bus.hop_active,     m_phase == P_HOP);
        check("game_over",      bus.game_over,      m_phase == P_OVER);
    endtask

    task automatic drive(input bit ft, input bit [3:0] k, input bit col, input bit hm, input bit rs);
        bus.frame_tick   = ft;
        bus.key_up       = k[3];
        bus.key_down     = k[2];
        bus.key_left     = k[1];
        bus.key_right    = k[0];
        bus.collision    = col;
        bus.reached_home = hm;
        bus.restart      = rs;
    endtask

    initial begin
        bit [3:0] keys;
        bit       ft, col, hm, rs;
        int       n_resets;
        keys = 4'b0;
        n_resets = 0;
        RESETn = 1'b0;
        drive(1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        repeat (3) @(negedge CLK);
        #1 check_outputs(1'b0);
        @(negedge CLK);
        RESETn = 1'b1;

        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(negedge CLK);
            ft = ($urandom_range(0, 2) == 0);
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 15) == 0) keys[b] = ~keys[b];
            col = ($urandom_range(0, 299) == 0);
            hm  = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 599) == 0) begin col = 1'b1; hm = 1'b1; end
            rs  = ($urandom_range(0, 29) == 0);
            drive(ft, keys, col, hm, rs);
            #1 check_outputs(ft);
            model_clock(ft, keys, col, hm, rs);

            // Asynchronous reset landing in the middle of a hop
            if (cyc > 1000 && n_resets < 4 && m_phase == P_HOP && $urandom_range(0, 39) == 0) begin
                n_resets++;
                #5;
                keys = 4'b0;
                drive(1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
                RESETn = 1'b0;
                model_reset();
                #1 check_outputs(1'b0);
                @(negedge CLK);
                RESETn = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
